fmul_flow_ctrl: RTL and testbench
=================================

FMUL_FLOW_CTRL -- requirements
Module: fmul_flow_ctrl

Interface
REQ-001 Parameter OUT_DEPTH, default 4: result FIFO entries, power of two, 2..16.
REQ-002 Parameter MUL_LAT, default 2: enabled cycles from multiplier input to valid output_z.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, synchronous, active-low; also wired to the multiplier's clrn.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  operand pair accepted when in_valid and in_ready are both high.
REQ-007 in_a, in_b  input  32  FP32 operands.
REQ-008 mul_a, mul_b  output  32  operands driven to the multiplier.
REQ-009 mul_enable  output  1  pipeline advance to the multiplier's enable input.
REQ-010 mul_z  input  32  multiplier output_z.
REQ-011 out_valid  output  1  result available at FIFO head.
REQ-012 out_ready  input  1  consumer accepts head when out_valid is also high.
REQ-013 out_z  output  32  FIFO head result.
REQ-014 busy  output  1  high while any valid token is in flight or the FIFO is non-empty.
REQ-015 fifo_count  output  $clog2(OUT_DEPTH)+1  FIFO occupancy.

Function
REQ-016 A valid-token shift register vld[MUL_LAT-1:0] shall shadow the multiplier pipeline:
- It shifts only when mul_enable=1.
- vld[0] loads the in-handshake.
REQ-017 pop = out_valid & out_ready; space = (fifo_count < OUT_DEPTH) | pop.
REQ-018 mul_enable shall be combinational: !vld[MUL_LAT-1] | space. Bubbles therefore collapse and the pipeline stalls only when a valid result cannot be written.
REQ-019 in_ready = mul_enable; in_ready shall not depend on in_valid.
REQ-020 mul_a/mul_b shall equal in_a/in_b when in_valid & in_ready; otherwise they shall be 32'h0.
REQ-021 FIFO write = mul_enable & vld[MUL_LAT-1]; data = mul_z, sampled in the same cycle.
REQ-022 Latency: a pair accepted in cycle 0 shall appear on out_z with out_valid=1 in cycle MUL_LAT+1 (cycle 3 by default) when no stall occurs. There is no FIFO bypass.
REQ-023 Throughput: one result per cycle when out_ready is held high.
REQ-024 Ordering: results shall leave in acceptance order; no drop, no duplication.
REQ-025 Simultaneous write and pop when the FIFO is full shall be legal; occupancy stays at OUT_DEPTH.
REQ-026 Simultaneous write and pop when the FIFO is empty: out_valid rises next cycle with the written entry.
REQ-027 Pop when empty shall be ignored; pointers wrap modulo OUT_DEPTH.
REQ-028 While mul_enable=0, vld, mul_z and the FIFO write path shall hold; out_valid/out_z stay stable until popped.

Reset
REQ-029 When clrn=0 at a rising edge, the block shall clear vld, the FIFO pointers and fifo_count. After that edge: out_valid=0, busy=0, fifo_count=0.
REQ-030 During reset, mul_enable=1, in_ready=1 and mul_a/mul_b=0, and any in-handshake is discarded.
REQ-031 Reset mid-operation shall drop all in-flight and buffered results; no stale result shall appear after clrn returns high.
REQ-032 out_z is undefined while out_valid=0.

Structure
REQ-033 Shared package fmul_pkg shall hold FP32_W=32, default MUL_LAT=2, default OUT_DEPTH=4, and the FP32 word typedef.
REQ-034 The FIFO shall be the sub-module fmul_result_fifo (sync reset, count output). The token tracker and enable logic stay in the top level.
REQ-035 The block shall instantiate no multiplier; it connects to one through the mul_* ports.

Verification
REQ-036 Single op: accept 0x40000000 x 0x40400000 in cycle 0 -> out_valid in cycle 3, out_z=0x40C00000.
REQ-037 Back-to-back stream with out_ready=1 (pairs 0x3FC00000x0x3FC00000, 0xBF800000x0x3F800000, 0x7F800000x0x40000000) -> out_z 0x40100000, 0xBF800000, 0x7F800000 in consecutive cycles 3..5.
REQ-038 Backpressure: out_ready=0, issue 8 ops -> fifo_count=4, then mul_enable=0 and in_ready=0 with 2 tokens held. Raising out_ready -> all 8 results in order, none lost.
REQ-039 Full write+pop: FIFO full and vld[1]=1 with out_ready=1 -> mul_enable=1, fifo_count stays 4.
REQ-040 Reset mid-stream: clrn=0 for 1 cycle with 2 tokens in flight and 3 buffered -> out_valid=0, fifo_count=0, busy=0, and no result emitted afterward.
REQ-041 Bubble collapse: in_valid=0 gaps with out_ready=0 and FIFO full -> in_ready stays 1 until a valid token reaches vld[1].

Source files
------------

// File: rtl/fmul_pkg.sv
// Shared widths, default parameters and the FP32 word type for the FP multiplier flow controller.
package fmul_pkg;
  localparam int unsigned FP32_W            = 32;
  localparam int unsigned MUL_LAT_DEFAULT   = 2;
  localparam int unsigned OUT_DEPTH_DEFAULT = 4;

  typedef logic [FP32_W-1:0] fp32_t;
endpackage

// File: rtl/fmul_result_fifo.sv
// Result FIFO with synchronous active-low reset and an occupancy count.
// A write into a full FIFO is accepted only when it is paired with a pop.
module fmul_result_fifo
  import fmul_pkg::*;
#(
  parameter int unsigned DEPTH = OUT_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     wr_en_i,
  input  fp32_t                    wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output fp32_t                    rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fp32_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = rd_en_i & (count_q != '0);
  assign do_push = wr_en_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// File: rtl/fmul_flow_ctrl.sv
// Valid/ready wrapper around an external enable-stalled FP32 multiplier pipeline.
// A token shift register shadows the pipeline; results land in a small FIFO.
module fmul_flow_ctrl
  import fmul_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEFAULT,
  parameter int unsigned MUL_LAT   = MUL_LAT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FP32_W-1:0]           in_a,
  input  logic [FP32_W-1:0]           in_b,
  output logic [FP32_W-1:0]           mul_a,
  output logic [FP32_W-1:0]           mul_b,
  output logic                        mul_enable,
  input  logic [FP32_W-1:0]           mul_z,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FP32_W-1:0]           out_z,
  output logic                        busy,
  output logic [$clog2(OUT_DEPTH):0]  fifo_count
);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic               in_fire;
  logic               pop;
  logic               space;
  logic               fifo_wr;

  assign pop   = out_valid & out_ready;
  assign space = (fifo_count < CNT_W'(OUT_DEPTH)) | pop;

  // Stall only when the oldest stage holds a real result with nowhere to go.
  assign mul_enable = !clrn | !vld_q[MUL_LAT-1] | space;
  assign in_ready   = mul_enable;
  assign in_fire    = clrn & in_valid & in_ready;
  assign mul_a      = in_fire ? in_a : '0;
  assign mul_b      = in_fire ? in_b : '0;
  assign fifo_wr    = clrn & mul_enable & vld_q[MUL_LAT-1];

  always_comb begin
    vld_d = vld_q;
    if (mul_enable) vld_d = (vld_q << 1) | MUL_LAT'(in_fire);
  end

  always_ff @(posedge clk) begin
    if (!clrn) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  fmul_result_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .clrn       (clrn),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (mul_z),
    .rd_en_i    (out_ready),
    .rd_valid_o (out_valid),
    .rd_data_o  (out_z),
    .count_o    (fifo_count)
  );

  assign busy = (|vld_q) | out_valid;
endmodule

// File: tb/tb_fmul_flow_ctrl.sv
// Scoreboard bench for fmul_flow_ctrl with a 2-stage enabled multiplier stub.
module tb_fmul_flow_ctrl;
  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] mul_a, mul_b;
  logic        mul_enable;
  logic [31:0] mul_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        busy;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fmul_flow_ctrl #(.OUT_DEPTH(4), .MUL_LAT(2)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_enable (mul_enable),
    .mul_z      (mul_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Multiplier stand-in: products for the directed pairs only.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000) return b;
    case ({a, b})
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;
      {32'hBF80_0000, 32'h3F80_0000}: return 32'hBF80_0000;
      {32'h7F80_0000, 32'h4000_0000}: return 32'h7F80_0000;
      default:                        return a ^ b;
    endcase
  endfunction

  logic [31:0] s0, s1;
  always @(posedge clk) begin
    if (!clrn) begin
      s0 <= '0;
      s1 <= '0;
    end else if (mul_enable) begin
      s0 <= fmul_ref(mul_a, mul_b);
      s1 <= s0;
    end
  end
  assign mul_z = s1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is matched against the scoreboard head.
  always @(negedge clk) begin
    if (clrn && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got %h expected none", out_z);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_z !== e) begin
          bad++;
          $display("FAIL out_z: got %h expected %h", out_z, e);
        end
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z, input bit expect_out);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 32'(in_ready), 32'd1);
    chk("mul_a_pass", mul_a, a);
    @(posedge clk);
    if (expect_out) exp_q.push_back(z);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clrn      = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h1234_5678;
    in_b      = 32'h9ABC_DEF0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_mul_enable", 32'(mul_enable), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mul_a", mul_a, 32'h0);
    chk("rst_mul_b", mul_b, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    clrn     = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("idle_mul_a", mul_a, 32'h0);
    @(posedge clk);
    #1;

    // Single op latency: accepted in cycle 0, visible in cycle 3.
    out_ready = 1'b1;
    issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
    @(negedge clk); chk("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_c3", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Back-to-back stream, results in cycles 3..5.
    issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1);
    issue(32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b1);
    issue(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1);
    @(negedge clk); chk("str_c3", 32'(out_valid), 32'd1);
    @(negedge clk); chk("str_c4", 32'(out_valid), 32'd1);
    @(negedge clk); chk("str_c5", 32'(out_valid), 32'd1);
    @(negedge clk); chk("str_c6", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    drain();

    // Backpressure: 6 accepted, 7th stalls with FIFO full and 2 tokens held.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      issue(32'h3F80_0000, 32'h4100_0000 + 32'(i << 16), 32'h4100_0000 + 32'(i << 16), 1'b1);
    in_valid = 1'b1;
    in_a     = 32'h3F80_0000;
    in_b     = 32'h4106_0000;
    @(negedge clk);
    chk("bp_count", 32'(fifo_count), 32'd4);
    chk("bp_mul_enable", 32'(mul_enable), 32'd0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_head", out_z, 32'h4100_0000);
    @(negedge clk);
    @(negedge clk);
    chk("bp_hold_count", 32'(fifo_count), 32'd4);
    chk("bp_hold_head", out_z, 32'h4100_0000);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    // Full FIFO with a result waiting: write and pop in the same cycle.
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fwp_mul_enable", 32'(mul_enable), 32'd1);
    chk("fwp_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(32'h4106_0000);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fwp_count", 32'(fifo_count), 32'd4);
    @(posedge clk); #1;
    issue(32'h3F80_0000, 32'h4107_0000, 32'h4107_0000, 1'b1);
    drain();

    // Bubble collapse: full FIFO, empty pipeline keeps accepting.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(32'h3F80_0000, 32'h4200_0000 + 32'(i << 16), 32'h4200_0000 + 32'(i << 16), 1'b1);
    repeat (4) @(negedge clk);
    chk("bub_count", 32'(fifo_count), 32'd4);
    chk("bub_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(32'h3F80_0000, 32'h4204_0000, 32'h4204_0000, 1'b1);
    @(negedge clk); chk("bub_vld0_ready", 32'(in_ready), 32'd1);
    @(negedge clk); chk("bub_vld1_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    drain();

    // Reset with 2 tokens in flight and 3 buffered: everything dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(32'h3F80_0000, 32'h4300_0000 + 32'(i << 16), 32'h4300_0000 + 32'(i << 16), 1'b0);
    @(negedge clk);
    chk("mrst_pre_count", 32'(fifo_count), 32'd3);
    chk("mrst_pre_busy", 32'(busy), 32'd1);
    clrn     = 1'b0;
    in_valid = 1'b1;
    in_a     = 32'h3F80_0000;
    in_b     = 32'h4400_0000;
    #1;
    chk("mrst_mul_enable", 32'(mul_enable), 32'd1);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_mul_b", mul_b, 32'h0);
    @(posedge clk); #1;
    clrn     = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_count", 32'(fifo_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_no_stale", 32'(busy), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
